// File: rtl/regs_pkg.sv
// Shared defaults and constants for the multi-port register file.
// Imported by the register file top and its busy scoreboard.
package regs_pkg;

    localparam int DW_DEF   = 16;
    localparam int AW_DEF   = 4;
    localparam int NR_DEF   = 2;
    localparam int NW_DEF   = 1;

    // Address of the optionally hardwired zero register.
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/regs_scoreboard.sv
// Per-register pending (busy) bits: flush beats reserve, reserve beats write-clear.
// Looks up the busy bit of each registered read address.
module regs_scoreboard
    import regs_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int NR       = NR_DEF,
    parameter int NW       = NW_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NW-1:0]    wen,
    input  logic [NW*AW-1:0] waddr,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,
    input  logic             flush,
    input  logic [NR*AW-1:0] lookup_addr,
    output logic [NR-1:0]    rbusy
);

    localparam int DEPTH = 1 << AW;

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_next;

    // Applying clears before the set lets a same-cycle reservation win over a write.
    always_comb begin
        busy_next = busy;
        if (flush) begin
            busy_next = '0;
        end else begin
            for (int j = 0; j < NW; j++) begin
                if (wen[j]) busy_next[waddr[j*AW +: AW]] = 1'b0;
            end
            if (rsv_en) busy_next[rsv_addr] = 1'b1;
        end
        if (ZERO_REG != 0) busy_next[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= busy_next;
    end

    always_comb begin
        rbusy = '0;
        for (int i = 0; i < NR; i++) begin
            rbusy[i] = busy[lookup_addr[i*AW +: AW]];
        end
    end

endmodule

// File: rtl/regs_mp.sv
// Parametrised multi-port register file with registered read addresses,
// same-edge write visibility, optional zero register and busy scoreboard.
module regs_mp
    import regs_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int AW       = AW_DEF,
    parameter int NR       = NR_DEF,
    parameter int NW       = NW_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NR*AW-1:0] raddr,
    output logic [NR*DW-1:0] rdata,
    output logic [NR-1:0]    rbusy,
    input  logic [NW-1:0]    wen,
    input  logic [NW*AW-1:0] waddr,
    input  logic [NW*DW-1:0] wdata,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,
    input  logic             flush
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0]    mem [DEPTH];
    logic [NR*AW-1:0] raddr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) raddr_q <= '0;
        else        raddr_q <= raddr;
    end

    // NOTE: the array is reset like any other state so reads after reset are
    // defined; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
        end else begin
            // NOTE: later iterations override earlier non-blocking updates to
            // the same element, so the highest-indexed write port wins.
            for (int j = 0; j < NW; j++) begin
                if (wen[j] && !(ZERO_REG != 0 && waddr[j*AW +: AW] == AW'(REG_ZERO))) begin
                    mem[waddr[j*AW +: AW]] <= wdata[j*DW +: DW];
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NR; i++) begin
            rdata[i*DW +: DW] = mem[raddr_q[i*AW +: AW]];
        end
    end

    regs_scoreboard #(
        .AW       (AW),
        .NR       (NR),
        .NW       (NW),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .wen         (wen),
        .waddr       (waddr),
        .rsv_en      (rsv_en),
        .rsv_addr    (rsv_addr),
        .flush       (flush),
        .lookup_addr (raddr_q),
        .rbusy       (rbusy)
    );

endmodule

// File: tb/tb_regs_mp.sv
// Directed bench for regs_mp: default instance driven from a vector table,
// plus a ZERO_REG=0 / NW=2 instance for zero-register and dual-write cases.
module tb_regs_mp;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // Instance A: all defaults (ZERO_REG=1, NW=1)
    logic [7:0]  raddr_a;
    logic [31:0] rdata_a;
    logic [1:0]  rbusy_a;
    logic [0:0]  wen_a;
    logic [3:0]  waddr_a;
    logic [15:0] wdata_a;
    logic        rsv_en_a;
    logic [3:0]  rsv_addr_a;
    logic        flush_a;

    // Instance B: ZERO_REG=0, NW=2
    logic [7:0]  raddr_b;
    logic [31:0] rdata_b;
    logic [1:0]  rbusy_b;
    logic [1:0]  wen_b;
    logic [7:0]  waddr_b;
    logic [31:0] wdata_b;
    logic        rsv_en_b;
    logic [3:0]  rsv_addr_b;
    logic        flush_b;

    regs_mp u_dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .raddr    (raddr_a),
        .rdata    (rdata_a),
        .rbusy    (rbusy_a),
        .wen      (wen_a),
        .waddr    (waddr_a),
        .wdata    (wdata_a),
        .rsv_en   (rsv_en_a),
        .rsv_addr (rsv_addr_a),
        .flush    (flush_a)
    );

    regs_mp #(.NW(2), .ZERO_REG(0)) u_dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .raddr    (raddr_b),
        .rdata    (rdata_b),
        .rbusy    (rbusy_b),
        .wen      (wen_b),
        .waddr    (waddr_b),
        .wdata    (wdata_b),
        .rsv_en   (rsv_en_b),
        .rsv_addr (rsv_addr_b),
        .flush    (flush_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string       name;
        logic        wen;
        logic [3:0]  waddr;
        logic [15:0] wdata;
        logic        rsv_en;
        logic [3:0]  rsv_addr;
        logic        flush;
        logic [7:0]  raddr;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_rbusy;
    } vec_t;

    vec_t vecs [11];

    initial begin
        // Each row is applied before one edge and checked just after it.
        vecs[0]  = '{"reset_read",  1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b0, {4'd3, 4'd0}, 32'h0000_0000, 2'b00};
        vecs[1]  = '{"same_edge",   1'b1, 4'd5, 16'hBEEF, 1'b0, 4'd0, 1'b0, {4'd0, 4'd5}, 32'h0000_BEEF, 2'b00};
        vecs[2]  = '{"rsv_r9",      1'b0, 4'd0, 16'h0000, 1'b1, 4'd9, 1'b0, {4'd5, 4'd9}, 32'hBEEF_0000, 2'b01};
        vecs[3]  = '{"wr_clr_r9",   1'b1, 4'd9, 16'h00AA, 1'b0, 4'd0, 1'b0, {4'd9, 4'd5}, 32'h00AA_BEEF, 2'b00};
        vecs[4]  = '{"wr_rsv_r9",   1'b1, 4'd9, 16'h0055, 1'b1, 4'd9, 1'b0, {4'd5, 4'd9}, 32'hBEEF_0055, 2'b01};
        vecs[5]  = '{"zero_reg",    1'b1, 4'd0, 16'h1234, 1'b1, 4'd0, 1'b0, {4'd9, 4'd0}, 32'h0055_0000, 2'b10};
        vecs[6]  = '{"rsv_r2",      1'b0, 4'd0, 16'h0000, 1'b1, 4'd2, 1'b0, {4'd2, 4'd0}, 32'h0000_0000, 2'b10};
        vecs[7]  = '{"rsv_r3",      1'b0, 4'd0, 16'h0000, 1'b1, 4'd3, 1'b0, {4'd3, 4'd2}, 32'h0000_0000, 2'b11};
        vecs[8]  = '{"rsv_r4",      1'b0, 4'd0, 16'h0000, 1'b1, 4'd4, 1'b0, {4'd4, 4'd9}, 32'h0000_0055, 2'b11};
        vecs[9]  = '{"flush_rsv6",  1'b1, 4'd2, 16'h0777, 1'b1, 4'd6, 1'b1, {4'd6, 4'd2}, 32'h0000_0777, 2'b00};
        vecs[10] = '{"post_flush",  1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b0, {4'd9, 4'd4}, 32'h0055_0000, 2'b00};

        rst_n      = 1'b0;
        raddr_a    = {4'd3, 4'd0};
        wen_a      = 1'b0;
        waddr_a    = '0;
        wdata_a    = '0;
        rsv_en_a   = 1'b0;
        rsv_addr_a = '0;
        flush_a    = 1'b0;
        raddr_b    = '0;
        wen_b      = '0;
        waddr_b    = '0;
        wdata_b    = '0;
        rsv_en_b   = 1'b0;
        rsv_addr_b = '0;
        flush_b    = 1'b0;

        step();
        check("in_reset_rdata", rdata_a, 32'h0);
        check("in_reset_rbusy", {30'b0, rbusy_a}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 11; v++) begin
            wen_a      = vecs[v].wen;
            waddr_a    = vecs[v].waddr;
            wdata_a    = vecs[v].wdata;
            rsv_en_a   = vecs[v].rsv_en;
            rsv_addr_a = vecs[v].rsv_addr;
            flush_a    = vecs[v].flush;
            raddr_a    = vecs[v].raddr;
            step();
            check({vecs[v].name, "_rdata"}, rdata_a, vecs[v].exp_rdata);
            check({vecs[v].name, "_rbusy"}, {30'b0, rbusy_a}, {30'b0, vecs[v].exp_rbusy});
        end
        wen_a    = 1'b0;
        rsv_en_a = 1'b0;
        flush_a  = 1'b0;

        // Address change alone must not move rdata until the next edge.
        raddr_a = {4'd5, 4'd5};
        #2;
        check("latency_before_edge", rdata_a, 32'h0055_0000);
        step();
        check("latency_after_edge", rdata_a, 32'hBEEF_BEEF);

        // ZERO_REG=0: r0 is an ordinary register.
        wen_b      = 2'b01;
        waddr_b    = {4'd0, 4'd0};
        wdata_b    = {16'h0000, 16'h1234};
        rsv_en_b   = 1'b1;
        rsv_addr_b = 4'd0;
        raddr_b    = {4'd0, 4'd0};
        step();
        check("nz_r0_rdata", rdata_b, 32'h1234_1234);
        check("nz_r0_rbusy", {30'b0, rbusy_b}, 32'h3);

        // Both write ports hit r7; port 1 must win.
        wen_b    = 2'b11;
        waddr_b  = {4'd7, 4'd7};
        wdata_b  = {16'h2222, 16'h1111};
        rsv_en_b = 1'b0;
        raddr_b  = {4'd0, 4'd7};
        step();
        check("dual_wr_r7_rdata", rdata_b, 32'h1234_2222);
        check("dual_wr_r7_rbusy", {30'b0, rbusy_b}, 32'h2);
        wen_b = 2'b00;

        // Reserve r8 so the asynchronous reset has a busy bit to clear.
        rsv_en_b   = 1'b1;
        rsv_addr_b = 4'd8;
        raddr_b    = {4'd7, 4'd8};
        step();
        rsv_en_b = 1'b0;
        check("pre_rst_rbusy_b", {30'b0, rbusy_b}, 32'h1);

        // Mid-cycle asynchronous reset clears data and busy without an edge.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_rdata_a", rdata_a, 32'h0);
        check("async_rst_rdata_b", rdata_b, 32'h0);
        check("async_rst_rbusy_b", {30'b0, rbusy_b}, 32'h0);
        @(negedge clk);
        rst_n   = 1'b1;
        raddr_a = {4'd5, 4'd9};
        raddr_b = {4'd7, 4'd0};
        step();
        check("post_rst_rdata_a", rdata_a, 32'h0);
        check("post_rst_rdata_b", rdata_b, 32'h0);
        check("post_rst_rbusy_b", {30'b0, rbusy_b}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
